// File: rtl/solver_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : solver_dispatcher_pkg
// Purpose  : Shared types and widths for the polynomial solver dispatcher.
//            Holds the FSM state enum, operand widths, the packed FIFO entry
//            width and the default configuration values.
// Revision : 1.0 - initial release
// ============================================================================
package solver_dispatcher_pkg;

  localparam int X_W                    = 8;
  localparam int COEF_W                 = 16;
  localparam int ENTRY_W                = X_W + 3 * COEF_W;   // 56
  localparam int DEFAULT_DEPTH          = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Entry layout, MSB first: {X, A, B, C}
  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [X_W-1:0]    x,
    input logic [COEF_W-1:0] a,
    input logic [COEF_W-1:0] b,
    input logic [COEF_W-1:0] c
  );
    return {x, a, b, c};
  endfunction

endpackage
`default_nettype wire

// File: rtl/solver_dispatcher_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_fifo
// Purpose  : Synchronous FIFO of DEPTH entries (power of two) buffering
//            operand sets between the host and the dispatcher FSM.
// Ports    : clk, rst (async, active-high)
//            push/push_data  - write when push && !full
//            pop/pop_data    - pop_data shows the head; pop advances it
//            full, empty, level (occupancy, 0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_fifo
  import solver_dispatcher_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int             c_aw         = $clog2(DEPTH);
  localparam logic [c_aw:0]  c_full_level = (c_aw + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full      = (r_level == c_full_level);
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  // Storage carries no reset; occupancy tracking alone defines validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push_ok && !w_pop_ok) begin
        r_level <= r_level + 1'b1;
      end else if (!w_push_ok && w_pop_ok) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/solver_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : solver_dispatcher
// Purpose  : Upstream feeder for the polynomial solver core. Buffers host
//            operand sets in a FIFO, issues one job at a time to the solver
//            with a start/completed handshake and returns each result in a
//            single-entry valid/ready output slot.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready, in_x, in_a, in_b, in_c   - host side
//            sol_start, sol_x/a/b/c                     - solver operands
//            sol_result, sol_zero, sol_overflow,
//            sol_completed                              - solver results
//            out_valid/out_ready, out_result, out_zero,
//            out_overflow, out_timeout                  - result slot
//            level (FIFO occupancy), busy (FSM not idle)
// Options  : SOLVER_DISPATCH_TIMEOUT_EN - abandon a job after TIMEOUT_CYCLES
//            WAIT cycles and return an overflow/timeout result.
// Revision : 1.0 - initial release
// ============================================================================
module solver_dispatcher
  import solver_dispatcher_pkg::*;
#(
  parameter int DEPTH          = DEFAULT_DEPTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [X_W-1:0]         in_x,
  input  logic [COEF_W-1:0]      in_a,
  input  logic [COEF_W-1:0]      in_b,
  input  logic [COEF_W-1:0]      in_c,
  output logic                   sol_start,
  output logic [X_W-1:0]         sol_x,
  output logic [COEF_W-1:0]      sol_a,
  output logic [COEF_W-1:0]      sol_b,
  output logic [COEF_W-1:0]      sol_c,
  input  logic [COEF_W-1:0]      sol_result,
  input  logic                   sol_zero,
  input  logic                   sol_overflow,
  input  logic                   sol_completed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COEF_W-1:0]      out_result,
  output logic                   out_zero,
  output logic                   out_overflow,
  output logic                   out_timeout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("solver_dispatcher: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  state_t             r_state;
  state_t             w_next_state;
  logic               r_comp_q;
  logic               w_comp_edge;
  logic               w_slot_free;
  logic               w_pop;
  logic               w_capture;
  logic               w_expire_capture;
  logic               w_expired;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic [ENTRY_W-1:0] w_head;

  assign in_ready    = !w_full;
  assign w_push      = in_valid && in_ready;
  // A completed level held over from an earlier job produces no edge until
  // it has been sampled low at least once.
  assign w_comp_edge = sol_completed && !r_comp_q;
  // Slot can take a new job if empty now or being drained this cycle.
  assign w_slot_free = !out_valid || out_ready;
  assign sol_start   = (r_state == ISSUE);
  assign busy        = (r_state != IDLE);

  dispatch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (pack_entry(in_x, in_a, in_b, in_c)),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (level)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_pop            = 1'b0;
    w_capture        = 1'b0;
    w_expire_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && w_slot_free) begin
          w_pop        = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        w_next_state = WAIT;
      end
      WAIT: begin
        // A real completion edge wins over a simultaneous expiry.
        if (w_comp_edge) begin
          w_capture    = 1'b1;
          w_next_state = IDLE;
        end else if (w_expired) begin
          w_expire_capture = 1'b1;
          w_next_state     = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_comp_q     <= 1'b0;
      sol_x        <= '0;
      sol_a        <= '0;
      sol_b        <= '0;
      sol_c        <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      r_comp_q <= sol_completed;
      if (w_pop) begin
        {sol_x, sol_a, sol_b, sol_c} <= w_head;
      end
      if (w_capture) begin
        out_valid    <= 1'b1;
        out_result   <= sol_result;
        out_zero     <= sol_zero;
        out_overflow <= sol_overflow;
      end else if (w_expire_capture) begin
        out_valid    <= 1'b1;
        out_result   <= '0;
        out_zero     <= 1'b0;
        out_overflow <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SOLVER_DISPATCH_TIMEOUT_EN
  localparam int              c_cnt_w     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_last_wait = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_wait_cnt;

  // Counter rests at zero outside WAIT, so each WAIT entry starts fresh;
  // it reads k-1 on the k-th WAIT cycle.
  assign w_expired = (r_state == WAIT) && (r_wait_cnt == c_last_wait);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt  <= '0;
      out_timeout <= 1'b0;
    end else begin
      if (r_state != WAIT) begin
        r_wait_cnt <= '0;
      end else if (!w_expired) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_capture) begin
        out_timeout <= 1'b0;
      end else if (w_expire_capture) begin
        out_timeout <= 1'b1;
      end
    end
  end
`else
  assign w_expired   = 1'b0;
  assign out_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_solver_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_solver_dispatcher
// Purpose  : Self-checking bench for solver_dispatcher with a behavioural
//            solver stub and a queue-based expected-result model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_solver_dispatcher;
  import solver_dispatcher_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [X_W-1:0]         in_x = '0;
  logic [COEF_W-1:0]      in_a = '0, in_b = '0, in_c = '0;
  logic                   sol_start;
  logic [X_W-1:0]         sol_x;
  logic [COEF_W-1:0]      sol_a, sol_b, sol_c;
  logic [COEF_W-1:0]      sol_result;
  logic                   sol_zero, sol_overflow;
  logic                   sol_completed;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [COEF_W-1:0]      out_result;
  logic                   out_zero, out_overflow, out_timeout;
  logic [$clog2(DEPTH):0] level;
  logic                   busy;

  always #5 clk = ~clk;

  solver_dispatcher #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .sol_start(sol_start), .sol_x(sol_x), .sol_a(sol_a), .sol_b(sol_b), .sol_c(sol_c),
    .sol_result(sol_result), .sol_zero(sol_zero), .sol_overflow(sol_overflow),
    .sol_completed(sol_completed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_overflow(out_overflow),
    .out_timeout(out_timeout), .level(level), .busy(busy)
  );

  // Solver stub: completed pulses for one cycle, 5 cycles after start.
  int   stub_cnt;
  logic stub_silent = 1'b0;
  assign sol_result   = sol_a ^ sol_c;
  assign sol_zero     = (sol_result == '0);
  assign sol_overflow = sol_b[15];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_cnt      <= 0;
      sol_completed <= 1'b0;
    end else begin
      sol_completed <= 1'b0;
      if (sol_start) begin
        stub_cnt <= 5;
      end else if (stub_cnt > 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1 && !stub_silent) sol_completed <= 1'b1;
      end
    end
  end

  // Reference model: each accepted operand set yields one result in order.
  typedef struct {
    logic [15:0] res;
    logic        zero;
    logic        ovf;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0, mismatched = 0;
  int   cyc = 0, starts = 0, n_accepted = 0;
  int   last_start_cyc = -1, last_push_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    if (sol_start) begin
      starts++;
      last_start_cyc = cyc;
    end
    if (!rst) chk("in_ready_vs_level", {31'd0, in_ready}, {31'd0, (level != DEPTH)});
    if (in_valid && in_ready) begin
      exp_t e;
      e.res  = in_a ^ in_c;
      e.zero = (e.res == 16'h0);
      e.ovf  = in_b[15];
      e.tmo  = 1'b0;
      exp_q.push_back(e);
      last_push_cyc = cyc;
      n_accepted++;
    end
    if (out_valid && out_ready) begin
      chk("model_has_entry", {31'd0, (exp_q.size() != 0)}, 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_result", {16'd0, out_result}, {16'd0, e.res});
        chk("out_zero", {31'd0, out_zero}, {31'd0, e.zero});
        chk("out_overflow", {31'd0, out_overflow}, {31'd0, e.ovf});
        chk("out_timeout", {31'd0, out_timeout}, {31'd0, e.tmo});
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_operands();
    in_x = X_W'($urandom);
    in_a = COEF_W'($urandom);
    in_b = COEF_W'($urandom);
    in_c = COEF_W'($urandom);
  endtask

  task automatic push_n(input int n);
    int target;
    int prev;
    target   = n_accepted + n;
    in_valid = 1'b1;
    rand_operands();
    for (int i = 0; i < 200 && n_accepted < target; i++) begin
      prev = n_accepted;
      tick();
      if (n_accepted != prev) rand_operands();
    end
    in_valid = 1'b0;
    chk("push_done", n_accepted, target);
  endtask

  task automatic wait_out_valid(input string tag);
    for (int i = 0; i < 60 && !out_valid; i++) tick();
    chk(tag, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_level"}, {28'd0, level}, 32'd0);
    chk({pfx, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({pfx, "_sol_start"}, {31'd0, sol_start}, 32'd0);
    chk({pfx, "_sol_xabc"}, {24'd0, sol_x} | {16'd0, sol_a} | {16'd0, sol_b} | {16'd0, sol_c}, 32'd0);
    chk({pfx, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({pfx, "_out_result"}, {16'd0, out_result}, 32'd0);
    chk({pfx, "_flags"}, {29'd0, out_zero, out_overflow, out_timeout}, 32'd0);
    chk({pfx, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int base;
    logic [15:0] held_res;
    logic held_zero, held_ovf;

    // ---- 1: reset state, single job, start latency, known result
    #1 rst = 1'b1;
    #10;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    in_x = 8'd3; in_a = 16'h0010; in_b = 16'h0002; in_c = 16'h0001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && starts == 0; i++) tick();
    chk("t1_start_latency", last_start_cyc - last_push_cyc, 2);
    wait_out_valid("t1_out_valid");
    chk("t1_result", {16'd0, out_result}, 32'h0011);
    chk("t1_flags", {29'd0, out_zero, out_overflow, out_timeout}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("t1_slot_cleared", {31'd0, out_valid}, 32'd0);

    // ---- 2: five back-to-back sets, FIFO fills, results in order
    base = starts;
    push_n(5);
    chk("t2_level_full", {28'd0, level}, 32'd4);
    chk("t2_in_ready_low", {31'd0, in_ready}, 32'd0);
    drain("t2_drained");
    chk("t2_one_start_per_job", starts - base, 5);

    // ---- 3: back-pressure holds the slot and blocks further starts
    out_ready = 1'b0;
    base = starts;
    push_n(3);
    wait_out_valid("t3_first_valid");
    held_res  = out_result;
    held_zero = out_zero;
    held_ovf  = out_overflow;
    s0 = starts;
    chk("t3_single_start", s0 - base, 1);
    for (int i = 0; i < 15; i++) tick();
    chk("t3_no_new_start", starts - s0, 0);
    chk("t3_held_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_held_result", {16'd0, out_result}, {16'd0, held_res});
    chk("t3_held_flags", {30'd0, out_zero, out_overflow}, {30'd0, held_zero, held_ovf});
    chk("t3_queued", {28'd0, level}, 32'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_out_valid("t3_second_valid");
    chk("t3_start_after_ready", starts - s0, 1);
    drain("t3_drained");

    // ---- 4: zero and overflow flags
    out_ready = 1'b0;
    in_x = X_W'($urandom);
    in_a = 16'h1234; in_b = 16'h8000; in_c = 16'h1234;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out_valid("t4_out_valid");
    chk("t4_result", {16'd0, out_result}, 32'd0);
    chk("t4_zero_ovf", {30'd0, out_zero, out_overflow}, 32'd3);
    drain("t4_drained");

    // ---- 5: reset during WAIT with jobs queued
    out_ready = 1'b1;
    push_n(4);
    chk("t5_busy", {31'd0, busy}, 32'd1);
    chk("t5_queued", {28'd0, level}, 32'd3);
    rst = 1'b1;
    #1;
    check_all_zero("t5_async");
    exp_q.delete();
    s0 = starts;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("t5_no_start_after", starts - s0, 0);
    chk("t5_idle_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_idle_level", {28'd0, level}, 32'd0);

`ifdef SOLVER_DISPATCH_TIMEOUT_EN
    // ---- 6: silent solver times out after TMO WAIT cycles
    stub_silent = 1'b1;
    out_ready   = 1'b0;
    s0 = starts;
    rand_operands();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_q[exp_q.size()-1].res  = 16'h0;
    exp_q[exp_q.size()-1].zero = 1'b0;
    exp_q[exp_q.size()-1].ovf  = 1'b1;
    exp_q[exp_q.size()-1].tmo  = 1'b1;
    for (int i = 0; i < 10 && starts == s0; i++) tick();
    wait_out_valid("t6_out_valid");
    // ISSUE cycle + TMO WAIT cycles, visible the cycle after expiry
    chk("t6_timeout_latency", cyc - last_start_cyc, TMO + 1);
    chk("t6_timeout_flag", {31'd0, out_timeout}, 32'd1);
    chk("t6_overflow", {31'd0, out_overflow}, 32'd1);
    chk("t6_result_zero", {15'd0, out_result, out_zero}, 32'd0);
    drain("t6_drained");
    stub_silent = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
